kernel_bc_fifo_rd_adapter: RTL and testbench

//  Read-side consumer for the kernel_bc ap_fifo channels: on start, pops exactly LEN words from an

---
 rtl/kernel_bc_fifo_rd_pkg.sv | 17 +
 rtl/kernel_bc_fifo_rd_skid.sv | 81 ++++++++
 rtl/kernel_bc_fifo_rd_adapter.sv | 122 ++++++++++++
 tb/tb_kernel_bc_fifo_rd_adapter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_bc_fifo_rd_pkg.sv
// Shared types and constants for the kernel_bc FIFO read adapter.
package kernel_bc_fifo_rd_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_W      = 16;

    localparam int BUF_DEPTH = 2;
    localparam int COUNT_W   = 2;
    localparam logic [COUNT_W-1:0] BUF_FULL = COUNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/kernel_bc_fifo_rd_skid.sv
// Two-entry data+last buffer. The head entry doubles as the registered output stage,
// so a pushed word is visible on o_data/o_valid one cycle after the push.
module kernel_bc_fifo_rd_skid
    import kernel_bc_fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [COUNT_W-1:0]    o_count
);

    logic [DATA_WIDTH-1:0] r_head_data;
    logic                  r_head_last;
    logic [DATA_WIDTH-1:0] r_tail_data;
    logic                  r_tail_last;
    logic [COUNT_W-1:0]    r_count;
    logic                  w_pop;

    assign w_pop   = (r_count != '0) && i_ready;
    assign o_valid = (r_count != '0);
    assign o_data  = r_head_data;
    assign o_last  = r_head_last;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_count)
                COUNT_W'(0): begin
                    if (i_push) begin
                        r_head_data <= i_data;
                        r_head_last <= i_last;
                        r_count     <= COUNT_W'(1);
                    end
                end
                COUNT_W'(1): begin
                    case ({i_push, w_pop})
                        2'b11: begin
                            r_head_data <= i_data;
                            r_head_last <= i_last;
                        end
                        2'b10: begin
                            r_tail_data <= i_data;
                            r_tail_last <= i_last;
                            r_count     <= COUNT_W'(2);
                        end
                        2'b01: r_count <= COUNT_W'(0);
                        default: ;
                    endcase
                end
                default: begin
                    // Full: the tail advances into the head; a push is only taken alongside a pop.
                    if (w_pop) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        if (i_push) begin
                            r_tail_data <= i_data;
                            r_tail_last <= i_last;
                        end else begin
                            r_count <= COUNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/kernel_bc_fifo_rd_adapter.sv
// Pops exactly len words from an ap_fifo read port and streams them out with out_last.
// Optional XOR checksum output chk when KERNEL_BC_FIFO_RD_XOR_EN is defined.
module kernel_bc_fifo_rd_adapter
    import kernel_bc_fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  idle,
    output logic                  done,
    input  logic                  if_empty_n,
    output logic                  if_read,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef KERNEL_BC_FIFO_RD_XOR_EN
    ,
    output logic [DATA_WIDTH-1:0] chk
`endif
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_idle;
    logic               r_done;
    logic               w_if_read;
    logic               w_pop;
    logic               w_xfer;
    logic               w_last_pop;
    logic [COUNT_W-1:0] w_count;

    // Pop request is a function of registers only, so it never combinationally follows the sink.
    assign w_if_read  = (r_state == RUN) && (r_remaining != '0) && (w_count < BUF_FULL);
    assign w_pop      = w_if_read && if_empty_n;
    assign w_last_pop = (r_remaining == LEN_W'(1));
    assign w_xfer     = out_valid && out_ready;

    assign if_read = w_if_read;
    assign idle    = r_idle;
    assign done    = r_done;

    kernel_bc_fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_pop),
        .i_data  (if_dout),
        .i_last  (w_last_pop),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_last  (out_last),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_idle      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_remaining <= len;
                            r_state     <= RUN;
                            r_idle      <= 1'b0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_pop) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last_pop) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_xfer && out_last) begin
                        r_state <= IDLE;
                        r_idle  <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

`ifdef KERNEL_BC_FIFO_RD_XOR_EN
    logic [DATA_WIDTH-1:0] r_chk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chk <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_chk <= '0;
        end else if (w_pop) begin
            r_chk <= r_chk ^ if_dout;
        end
    end

    assign chk = r_chk;
`endif

endmodule

// File: tb/tb_kernel_bc_fifo_rd_adapter.sv
// Directed bench for kernel_bc_fifo_rd_adapter; covers the XOR checksum when
// KERNEL_BC_FIFO_RD_XOR_EN is defined.
module tb_kernel_bc_fifo_rd_adapter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] len;
    logic        idle;
    logic        done;
    logic        if_empty_n;
    logic        if_read;
    logic [31:0] if_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
`ifdef KERNEL_BC_FIFO_RD_XOR_EN
    logic [31:0] chk;
`endif

    kernel_bc_fifo_rd_adapter #(
        .DATA_WIDTH (32),
        .LEN_W      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .idle       (idle),
        .done       (done),
        .if_empty_n (if_empty_n),
        .if_read    (if_read),
        .if_dout    (if_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
`ifdef KERNEL_BC_FIFO_RD_XOR_EN
        ,
        .chk        (chk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] rx_data[$];
    logic        rx_last[$];
    logic [31:0] exp_q[$];
    logic        gate;
    int          cyc;
    int          pops;
    int          dones;
    int          done_cyc;
    int          last_xfer_cyc;
    int          first_pop_cyc;
    int          last_pop_cyc;
    bit          rd_seen;
    bit          ov_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rx_data.delete();
        rx_last.delete();
        exp_q.delete();
        fifo_q.delete();
        pops = 0; dones = 0; done_cyc = -1; last_xfer_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1; rd_seen = 0; ov_seen = 0;
    endtask

    // One clock: model the upstream FIFO, log pops/transfers/done.
    task automatic step();
        bit          p, x;
        logic [31:0] xd;
        logic        xl;
        logic [31:0] dmy;
        if_empty_n = gate && (fifo_q.size() != 0);
        if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        #0;
        p  = if_read && if_empty_n;
        x  = out_valid && out_ready;
        xd = out_data;
        xl = out_last;
        if (if_read) rd_seen = 1;
        if (out_valid) ov_seen = 1;
        @(posedge clk);
        #1;
        if (p) begin
            dmy = fifo_q.pop_front();
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (x) begin
            rx_data.push_back(xd);
            rx_last.push_back(xl);
            last_xfer_cyc = cyc;
            $display("xfer cyc=%0d data=%08h last=%0b", cyc, xd, xl);
        end
        cyc++;
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        if_empty_n = gate && (fifo_q.size() != 0);
        if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic run_done(input int limit);
        int n;
        int d0;
        n  = 0;
        d0 = dones;
        while (dones == d0 && n < limit) begin
            step();
            n++;
        end
        check("done_within_bound", 64'(dones - d0), 64'd1);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, 64'(rx_data.size()), 64'(exp_q.size()));
        for (int i = 0; i < rx_data.size() && i < exp_q.size(); i++) begin
            check({tag, "_data"}, 64'(rx_data[i]), 64'(exp_q[i]));
            check({tag, "_last"}, 64'(rx_last[i]), 64'(i == exp_q.size() - 1));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; out_ready = 1'b0;
        gate = 1'b1; if_empty_n = 1'b0; if_dout = '0; cyc = 0;
        clear_log();

        // Reset state
        step(); step();
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_if_read", 64'(if_read), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        step();

        // 1: len=4 at full rate
        clear_log();
        fifo_q = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
        exp_q  = fifo_q;
        out_ready = 1'b1; gate = 1'b1;
        start = 1'b1; len = 16'd4;
        step();
        start = 1'b0;
        check("t1_busy", 64'(idle), 64'd0);
        run_done(50);
        check("t1_pops", 64'(pops), 64'd4);
        check("t1_pop_span", 64'(last_pop_cyc - first_pop_cyc), 64'd3);
        check_rx("t1");
        check("t1_done_lat", 64'(done_cyc - last_xfer_cyc), 64'd1);
        check("t1_idle_after", 64'(idle), 64'd1);
        step();
        check("t1_done_pulse", 64'(done), 64'd0);

        // 2: len=0
        clear_log();
        fifo_q = '{32'h1111_1111};
        start = 1'b1; len = 16'd0;
        step();
        start = 1'b0;
        check("t2_done", 64'(done), 64'd1);
        check("t2_idle", 64'(idle), 64'd1);
        repeat (4) step();
        check("t2_no_read", 64'(rd_seen), 64'd0);
        check("t2_no_valid", 64'(ov_seen), 64'd0);
        check("t2_done_once", 64'(dones), 64'd1);

        // 3: len=8 with backpressure
        clear_log();
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h3000_0000 + 32'(i * 7 + 1));
        exp_q = fifo_q;
        out_ready = 1'b0;
        start = 1'b1; len = 16'd8;
        step();
        start = 1'b0;
        repeat (6) step();
        check("t3_pops_stalled", 64'(pops), 64'd2);
        check("t3_read_low", 64'(if_read), 64'd0);
        check("t3_hold_valid", 64'(out_valid), 64'd1);
        check("t3_hold_data", 64'(out_data), 64'(exp_q[0]));
        out_ready = 1'b1;
        run_done(100);
        check("t3_pops", 64'(pops), 64'd8);
        check_rx("t3");

        // 4: len=3 with empty_n bubbles
        begin
            logic pat[6];
            int   exp_pops[6];
            pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            exp_pops = '{1, 1, 1, 2, 2, 3};
            clear_log();
            fifo_q = '{32'h4444_0001, 32'h4444_0002, 32'h4444_0003};
            exp_q  = fifo_q;
            start = 1'b1; len = 16'd3;
            step();
            start = 1'b0;
            for (int i = 0; i < 6; i++) begin
                gate = pat[i];
                step();
                check("t4_pops_step", 64'(pops), 64'(exp_pops[i]));
            end
            gate = 1'b1;
            run_done(50);
            check_rx("t4");
        end

        // 5: reset mid-transfer, then a fresh len=1 transfer
        clear_log();
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'h5500_0000 + 32'(i));
        start = 1'b1; len = 16'd5;
        step();
        start = 1'b0;
        step(); step();
        check("t5_pops_before_rst", 64'(pops), 64'd2);
        reset = 1'b1;
        step();
        check("t5_rst_idle", 64'(idle), 64'd1);
        check("t5_rst_done", 64'(done), 64'd0);
        check("t5_rst_if_read", 64'(if_read), 64'd0);
        check("t5_rst_out_valid", 64'(out_valid), 64'd0);
        check("t5_rst_out_last", 64'(out_last), 64'd0);
        check("t5_rst_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        repeat (3) step();
        check("t5_no_done", 64'(dones), 64'd0);
        clear_log();
        fifo_q = '{32'h5A5A_5A5A};
        exp_q  = fifo_q;
        start = 1'b1; len = 16'd1;
        step();
        start = 1'b0;
        run_done(30);
        check_rx("t5_new");

`ifdef KERNEL_BC_FIFO_RD_XOR_EN
        // 6: XOR checksum, ignored mid-RUN start
        clear_log();
        fifo_q = '{32'h0000_00FF, 32'h0000_0F0F, 32'hFFFF_0000, 32'h1234_5678};
        exp_q  = '{32'h0000_00FF, 32'h0000_0F0F, 32'hFFFF_0000};
        start = 1'b1; len = 16'd3;
        step();
        start = 1'b0;
        check("t6_chk_cleared", 64'(chk), 64'd0);
        step();
        start = 1'b1; len = 16'd9;
        step();
        start = 1'b0;
        check("t6_chk_mid", 64'(chk), 64'h0000_0FF0);
        run_done(50);
        check("t6_chk_done", 64'(chk), 64'hFFFF_0FF0);
        check("t6_pops", 64'(pops), 64'd3);
        check_rx("t6");
        repeat (2) step();
        check("t6_chk_stable", 64'(chk), 64'hFFFF_0FF0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
